// File: rtl/alg_frame_store_writer.sv
// Frame store writer: writes each camera frame line-by-line into a DDR slot ring via
// DataMover S2MM commands, then strobes frame_store/frame_type for the read stage.
module alg_frame_store_writer #(
    parameter int CACHE_WIDTH = 29,
    parameter int IMG_STRIDE  = 1024*1025,
    parameter int LINE_STRIDE = 1024,
    parameter int NUM_LINE    = 1024,
    parameter int NUM_SLOT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] base_addr,
    input  logic        load_addr,
    input  logic        frame_start,
    input  logic [1:0]  frame_type_i,
    input  logic        line_valid,
    output logic [71:0] s2mm_cmd_tdata,
    output logic        s2mm_cmd_tvalid,
    input  logic        s2mm_cmd_tready,
    input  logic [7:0]  s2mm_sts_tdata,
    input  logic        s2mm_sts_tvalid,
    output logic        s2mm_sts_tready,
    output logic        frame_store,
    output logic [1:0]  frame_type,
    output logic        wr_err,
    output logic        lost_line
);
    localparam int SLOT_W = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
    localparam int LINE_W = (NUM_LINE > 1) ? $clog2(NUM_LINE) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOT - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINE - 1);
    localparam logic [31:0]       IMG_STEP  = 32'(IMG_STRIDE);
    localparam logic [31:0]       LINE_STEP = 32'(LINE_STRIDE);

    typedef enum logic [2:0] {IDLE, WAIT, CMD, STS, LDONE, FDONE} state_t;
    state_t state, state_nxt;

    logic              load_d, load_p, init_flag, drain, cmd_valid;
    logic [31:0]       base_r, wr_addr, slot_off;
    logic [SLOT_W-1:0] slot;
    logic [LINE_W-1:0] line_cnt;
    logic [3:0]        pending;
    logic [1:0]        type_r;
    logic [2:0]        fs_cnt;
    logic              cmd_hs, start_ok, start_bad, line_in;
    logic              unused_bits;

    assign cmd_hs    = cmd_valid & s2mm_cmd_tready;
    assign start_ok  = init_flag & frame_start & (state == IDLE);
    assign start_bad = init_flag & frame_start & (state != IDLE);
    assign line_in   = init_flag & line_valid & (state != IDLE);
    assign slot_off  = 32'(slot) * IMG_STEP;

    assign s2mm_cmd_tdata  = {8'd0, base_r[31:CACHE_WIDTH], wr_addr[CACHE_WIDTH-1:0],
                              1'b0, 1'b1, 6'd0, 1'b1, 23'(LINE_STRIDE)};
    assign s2mm_cmd_tvalid = cmd_valid;
    // drain keeps the status channel open for a command orphaned by a re-init
    assign s2mm_sts_tready = (state == STS) | drain;
    assign frame_store     = (fs_cnt != 3'd0);
    assign unused_bits     = ^{wr_addr[31:CACHE_WIDTH], s2mm_sts_tdata[6:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load_p) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nxt = WAIT;
                WAIT:    if (pending != 4'd0 && !drain) state_nxt = CMD;
                CMD:     if (s2mm_cmd_tready) state_nxt = STS;
                STS:     if (s2mm_sts_tvalid) state_nxt = LDONE;
                LDONE:   state_nxt = (line_cnt == LINE_LAST) ? FDONE : WAIT;
                FDONE:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_d     <= 1'b0;
            load_p     <= 1'b0;
            init_flag  <= 1'b0;
            drain      <= 1'b0;
            cmd_valid  <= 1'b0;
            base_r     <= '0;
            wr_addr    <= '0;
            slot       <= '0;
            line_cnt   <= '0;
            pending    <= '0;
            type_r     <= '0;
            fs_cnt     <= '0;
            frame_type <= '0;
            wr_err     <= 1'b0;
            lost_line  <= 1'b0;
        end else begin
            load_d    <= load_addr;
            load_p    <= load_addr & ~load_d;
            cmd_valid <= (state_nxt == CMD);
            if (fs_cnt != 3'd0) fs_cnt <= fs_cnt - 3'd1;

            if (load_p) begin
                base_r    <= base_addr;
                slot      <= '0;
                line_cnt  <= '0;
                pending   <= '0;
                wr_err    <= 1'b0;
                lost_line <= 1'b0;
                init_flag <= 1'b1;
                drain     <= (drain & ~s2mm_sts_tvalid) | ((state == STS) & ~s2mm_sts_tvalid) | cmd_hs;
            end else begin
                if (drain && s2mm_sts_tvalid) drain <= 1'b0;
                if (start_bad) lost_line <= 1'b1;

                if (start_ok) begin
                    pending <= '0;
                end else if (line_in && !cmd_hs) begin
                    if (pending == 4'd15) lost_line <= 1'b1;
                    else                  pending   <= pending + 4'd1;
                end else if (cmd_hs && !line_in) begin
                    pending <= pending - 4'd1;
                end

                case (state)
                    IDLE: if (start_ok) begin
                        type_r   <= frame_type_i;
                        wr_addr  <= base_r + slot_off;
                        line_cnt <= '0;
                    end
                    STS: if (s2mm_sts_tvalid && !s2mm_sts_tdata[7]) wr_err <= 1'b1;
                    LDONE: if (line_cnt != LINE_LAST) begin
                        line_cnt <= line_cnt + LINE_W'(1);
                        wr_addr  <= wr_addr + LINE_STEP;
                    end
                    FDONE: begin
                        slot       <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
                        frame_type <= type_r;
                        fs_cnt     <= 3'd4;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alg_frame_store_writer.sv
// Scoreboard bench for alg_frame_store_writer: stimulus queues expected commands and
// frame types; a negedge monitor compares them against DUT handshakes and strobes.
`timescale 1ns/1ps
module tb_alg_frame_store_writer;
    logic        clk = 1'b0, rst_n = 1'b0, load_addr = 1'b0, frame_start = 1'b0, line_valid = 1'b0;
    logic [31:0] base_addr = '0;
    logic [1:0]  frame_type_i = '0;
    logic        s2mm_cmd_tready = 1'b0, s2mm_sts_tvalid = 1'b0;
    logic [7:0]  s2mm_sts_tdata = '0;
    logic [71:0] s2mm_cmd_tdata;
    logic        s2mm_cmd_tvalid, s2mm_sts_tready, frame_store, wr_err, lost_line;
    logic [1:0]  frame_type;

    alg_frame_store_writer #(
        .CACHE_WIDTH(29), .IMG_STRIDE(64), .LINE_STRIDE(16), .NUM_LINE(4), .NUM_SLOT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .load_addr(load_addr),
        .frame_start(frame_start), .frame_type_i(frame_type_i), .line_valid(line_valid),
        .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid),
        .s2mm_cmd_tready(s2mm_cmd_tready), .s2mm_sts_tdata(s2mm_sts_tdata),
        .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
        .frame_store(frame_store), .frame_type(frame_type), .wr_err(wr_err), .lost_line(lost_line)
    );

    always #5 clk = ~clk;

    int          vectors = 0, errors = 0;
    logic [71:0] exp_cmd_q[$];
    logic [1:0]  exp_ft_q[$];
    logic [7:0]  sts_q[$];
    int          outstanding = 0;
    bit          sts_en = 1'b1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Command word with BTT 16 for the bench geometry
    function automatic logic [71:0] cmd_word(input logic [31:0] base, input logic [31:0] addr);
        return {8'd0, base[31:29], addr[28:0], 1'b0, 1'b1, 6'd0, 1'b1, 23'd16};
    endfunction

    // One clock; also plays the DataMover status side (one status per accepted command)
    task automatic step();
        logic hs_cmd, hs_sts;
        @(negedge clk);
        hs_cmd = s2mm_cmd_tvalid & s2mm_cmd_tready;
        hs_sts = s2mm_sts_tvalid & s2mm_sts_tready;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_valid  = 1'b0;
        if (!rst_n) begin
            outstanding     = 0;
            s2mm_sts_tvalid = 1'b0;
        end else begin
            if (hs_sts) begin
                s2mm_sts_tvalid = 1'b0;
                outstanding--;
            end
            if (hs_cmd) outstanding++;
            if (sts_en && !s2mm_sts_tvalid && outstanding > 0) begin
                s2mm_sts_tvalid = 1'b1;
                s2mm_sts_tdata  = (sts_q.size() > 0) ? sts_q.pop_front() : 8'h80;
            end
        end
    endtask

    task automatic reload(input logic [31:0] base);
        base_addr = base;
        load_addr = 1'b0; step();
        load_addr = 1'b1; step(); step(); step();
    endtask

    task automatic run_frame(input logic [1:0] ft, input logic [31:0] base, input logic [31:0] first);
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(cmd_word(base, first + 32'(i * 16)));
        exp_ft_q.push_back(ft);
        frame_type_i = ft; frame_start = 1'b1; step();
        repeat (4) begin line_valid = 1'b1; step(); end
        repeat (40) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdata"}, s2mm_cmd_tdata, cmd_word(32'h0, 32'h0));
        check1({tag, "_tvalid"}, s2mm_cmd_tvalid, 1'b0);
        check1({tag, "_sts_tready"}, s2mm_sts_tready, 1'b0);
        check1({tag, "_frame_store"}, frame_store, 1'b0);
        check({tag, "_frame_type"}, 72'(frame_type), 72'd0);
        check1({tag, "_wr_err"}, wr_err, 1'b0);
        check1({tag, "_lost_line"}, lost_line, 1'b0);
    endtask

    // Monitor
    logic [71:0] prev_tdata = '0;
    logic        prev_stall = 1'b0, prev_fs = 1'b0;
    int          fs_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_fs    = 1'b0;
            fs_len     = 0;
        end else begin
            if (prev_stall && s2mm_cmd_tvalid) check("tdata_stable", s2mm_cmd_tdata, prev_tdata);
            if (s2mm_cmd_tvalid && s2mm_cmd_tready) begin
                if (exp_cmd_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL cmd_unexpected: got %h, expected no command", s2mm_cmd_tdata);
                end else begin
                    check("cmd", s2mm_cmd_tdata, exp_cmd_q.pop_front());
                end
            end
            prev_stall = s2mm_cmd_tvalid & ~s2mm_cmd_tready;
            prev_tdata = s2mm_cmd_tdata;
            if (frame_store) fs_len++;
            if (frame_store && !prev_fs) begin
                if (exp_ft_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL frame_store_unexpected: got strobe type %b, expected none", frame_type);
                end else begin
                    check("frame_type", 72'(frame_type), 72'(exp_ft_q.pop_front()));
                end
            end
            if (!frame_store && prev_fs) begin
                check("frame_store_len", 72'(fs_len), 72'd4);
                fs_len = 0;
            end
            prev_fs = frame_store;
        end
    end

    initial begin
        rst_n = 1'b0; step(); step();
        check_reset_outputs("reset");
        rst_n = 1'b1; step();

        // Not initialised yet: frame start and lines are ignored
        frame_type_i = 2'b01; frame_start = 1'b1; step();
        repeat (3) begin line_valid = 1'b1; step(); end
        repeat (8) step();
        check1("pre_init_tvalid", s2mm_cmd_tvalid, 1'b0);
        check1("pre_init_lost", lost_line, 1'b0);

        // 1: single frame
        s2mm_cmd_tready = 1'b1;
        reload(32'h2000_0000);
        run_frame(2'b01, 32'h2000_0000, 32'h000);
        check("t1_frame_type", 72'(frame_type), 72'd1);

        // 2: ring wrap over five frames
        reload(32'h2000_0000);
        run_frame(2'b10, 32'h2000_0000, 32'h000);
        run_frame(2'b11, 32'h2000_0000, 32'h040);
        run_frame(2'b00, 32'h2000_0000, 32'h080);
        run_frame(2'b01, 32'h2000_0000, 32'h0C0);
        run_frame(2'b10, 32'h2000_0000, 32'h000);

        // 3: backpressure, pending saturation (slot 1)
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(cmd_word(32'h2000_0000, 32'h040 + 32'(i * 16)));
        exp_ft_q.push_back(2'b11);
        s2mm_cmd_tready = 1'b0;
        frame_type_i = 2'b11; frame_start = 1'b1; step();
        repeat (10) step();
        repeat (15) begin line_valid = 1'b1; step(); end
        check1("t3_lost_before", lost_line, 1'b0);
        check1("t3_tvalid_held", s2mm_cmd_tvalid, 1'b1);
        line_valid = 1'b1; step();
        check1("t3_lost_sat", lost_line, 1'b1);
        s2mm_cmd_tready = 1'b1;
        repeat (40) step();
        check1("t3_lost_sticky", lost_line, 1'b1);

        // 4: status error on line 2 (slot 2)
        check1("t4_wr_err_before", wr_err, 1'b0);
        sts_q.push_back(8'h80); sts_q.push_back(8'h40);
        run_frame(2'b10, 32'h2000_0000, 32'h080);
        check1("t4_wr_err", wr_err, 1'b1);
        repeat (5) step();
        check1("t4_wr_err_sticky", wr_err, 1'b1);

        // 5: ignored start, then re-init mid-frame
        reload(32'h2000_0000);
        check1("t5_lost_cleared", lost_line, 1'b0);
        check1("t5_err_cleared", wr_err, 1'b0);
        check("t5_type_kept", 72'(frame_type), 72'd2);
        exp_cmd_q.push_back(cmd_word(32'h2000_0000, 32'h000));
        frame_type_i = 2'b01; frame_start = 1'b1; step();
        line_valid = 1'b1; step();
        frame_type_i = 2'b10; frame_start = 1'b1; step();
        check1("t5_lost_ignored_start", lost_line, 1'b1);
        repeat (10) step();
        s2mm_cmd_tready = 1'b0;
        line_valid = 1'b1; step();
        repeat (4) step();
        check1("t5_cmd_pending", s2mm_cmd_tvalid, 1'b1);
        reload(32'h6000_0000);
        check1("t5_cmd_dropped", s2mm_cmd_tvalid, 1'b0);
        check1("t5_lost_reinit", lost_line, 1'b0);
        s2mm_cmd_tready = 1'b1;
        repeat (10) step();
        run_frame(2'b10, 32'h6000_0000, 32'h000);

        // 6: reset while waiting for status (slot 1)
        sts_en = 1'b0;
        exp_cmd_q.push_back(cmd_word(32'h6000_0000, 32'h040));
        frame_type_i = 2'b11; frame_start = 1'b1; step();
        line_valid = 1'b1; step();
        repeat (5) step();
        check1("t6_in_sts", s2mm_sts_tready, 1'b1);
        rst_n = 1'b0; load_addr = 1'b0; step();
        check_reset_outputs("t6_reset");
        rst_n = 1'b1; sts_en = 1'b1; step();
        frame_type_i = 2'b01; frame_start = 1'b1; step();
        repeat (2) begin line_valid = 1'b1; step(); end
        repeat (8) step();
        check1("t6_ignored_tvalid", s2mm_cmd_tvalid, 1'b0);
        check1("t6_ignored_lost", lost_line, 1'b0);
        reload(32'h6000_0000);
        run_frame(2'b11, 32'h6000_0000, 32'h000);

        repeat (5) step();
        check("cmd_queue_drained", 72'(exp_cmd_q.size()), 72'd0);
        check("frame_queue_drained", 72'(exp_ft_q.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
